sap_clock_control: RTL and testbench

Clock-enable generator for the SAP-1 CPU core. It sits directly downstream of the pushbutton debouncers and consumes their single-cycle `PB_down` pulses. It selects between free-running (RUN) and single-step (STEP) operation, divides the board clock to a selectable CPU rate, and stops the CPU permanently when the control word asserts HLT. Every CPU register advances only on a `cpu_ce` cycle; the block never gates or generates a derived clock.

---
 rtl/sap_clock_control_if.sv | 37 +++
 rtl/sap_clock_control.sv | 122 ++++++++++++
 tb/tb_sap_clock_control.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sap_clock_control_if.sv
// ----------------------------------------------------------------------------
// sap_clock_control_if
//   Pushbutton/controller inputs and CPU clock-enable outputs of the SAP-1
//   clock control block.
//   master : the side that drives the buttons, speed select and HLT
//            (debouncers / CPU controller, or a testbench).
//   slave  : the clock control block itself.
//   Signals
//     mode_toggle : one-cycle pulse, flips RUN/STEP
//     step        : one-cycle pulse, one CPU cycle while in STEP
//     speed[1:0]  : rate select, divisor = DIV_MAX / 4**speed
//     hlt         : HLT level from the control word
//     cpu_ce      : registered one-cycle CPU clock enable
//     mode_run    : 1 = RUN, 0 = STEP
//     halted      : sticky halt indicator
//     clk_led     : toggles on every cpu_ce
// ----------------------------------------------------------------------------
interface sap_clock_control_if;
  logic       mode_toggle;
  logic       step;
  logic [1:0] speed;
  logic       hlt;
  logic       cpu_ce;
  logic       mode_run;
  logic       halted;
  logic       clk_led;

  modport master (
    output mode_toggle, step, speed, hlt,
    input  cpu_ce, mode_run, halted, clk_led
  );

  modport slave (
    input  mode_toggle, step, speed, hlt,
    output cpu_ce, mode_run, halted, clk_led
  );
endinterface

// File: rtl/sap_clock_control.sv
// ----------------------------------------------------------------------------
// sap_clock_control
//   Clock-enable generator for the SAP-1 CPU. Selects free-running (RUN) or
//   single-step (STEP) operation, divides clk down to the selected CPU rate
//   and stops the CPU for good once HLT is seen. No derived clock is made:
//   every CPU register advances only on a cpu_ce cycle.
//   Ports
//     clk : board clock, rising edge
//     clr : asynchronous, active-low reset (enters STEP)
//     bus : sap_clock_control_if.slave (buttons, speed, hlt in; ce/status out)
//   Parameters
//     DIV_WIDTH : divider counter width, must hold DIV_MAX-1
//     DIV_MAX   : divisor at speed 0
// ----------------------------------------------------------------------------
module sap_clock_control #(
  parameter int unsigned DIV_WIDTH = 24,
  parameter int unsigned DIV_MAX   = 12_500_000
) (
  input  logic                clk,
  input  logic                clr,
  sap_clock_control_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_STEP   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  state_e               state_q,   state_d;
  logic [DIV_WIDTH-1:0] cnt_q,     cnt_d;
  logic                 cpu_ce_q,  cpu_ce_d;
  logic                 clk_led_q, clk_led_d;

  logic [31:0] limit;
  logic [31:0] cnt_ext;
  logic        terminal;

  // Divider limit: each speed step divides the rate by 4. High speeds can
  // shift the limit down to 0, which is treated as 1 (ce every cycle).
  always_comb begin
    limit = DIV_MAX >> {bus.speed, 1'b0};
    if (limit == 32'd0) begin
      limit = 32'd1;
    end
  end

  assign cnt_ext  = 32'(cnt_q);
  // '>=' rather than '==' so that switching to a faster speed while cnt is
  // already past the new limit wraps on the next cycle instead of running
  // all the way round the counter.
  assign terminal = (cnt_ext >= (limit - 32'd1));

  // NOTE: every variable gets a default before the case so that no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cpu_ce_d = 1'b0;

    unique case (state_q)
      ST_STEP: begin
        cnt_d = '0;
        if (bus.hlt) begin
          state_d = ST_HALTED;
        end else if (bus.mode_toggle) begin
          state_d = ST_RUN;
        end else if (bus.step) begin
          cpu_ce_d = 1'b1;
        end
      end

      ST_RUN: begin
        if (bus.hlt) begin
          state_d = ST_HALTED;
          cnt_d   = '0;
        end else if (bus.mode_toggle) begin
          state_d = ST_STEP;
          cnt_d   = '0;
        end else if (terminal) begin
          cnt_d    = '0;
          cpu_ce_d = 1'b1;
        end else begin
          cnt_d = cnt_q + DIV_WIDTH'(1);
        end
      end

      ST_HALTED: begin
        // Only clr leaves this state; all inputs are ignored.
      end

      default: begin
        state_d = ST_STEP;
        cnt_d   = '0;
      end
    endcase

    clk_led_d = clk_led_q ^ cpu_ce_d;
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the values from before this edge.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= ST_STEP;
      cnt_q     <= '0;
      cpu_ce_q  <= 1'b0;
      clk_led_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cpu_ce_q  <= cpu_ce_d;
      clk_led_q <= clk_led_d;
    end
  end

  assign bus.cpu_ce   = cpu_ce_q;
  assign bus.clk_led  = clk_led_q;
  assign bus.mode_run = (state_q == ST_RUN);
  assign bus.halted   = (state_q == ST_HALTED);

endmodule

// File: tb/tb_sap_clock_control.sv
// ----------------------------------------------------------------------------
// tb_sap_clock_control
//   Directed bench for sap_clock_control with DIV_WIDTH = 8, DIV_MAX = 16.
//   A cycle-level model of the mode rules predicts every output; a compare
//   process checks the DUT against it on each falling edge. Directed
//   sections additionally check ce spacing and latency against hand-computed
//   numbers.
// ----------------------------------------------------------------------------
module tb_sap_clock_control;

  localparam int DW = 8;
  localparam int DM = 16;

  logic clk = 1'b0;
  logic clr;

  always #5 clk = ~clk;

  sap_clock_control_if bus ();

  sap_clock_control #(
    .DIV_WIDTH (DW),
    .DIV_MAX   (DM)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: mode, cycles elapsed since RUN entry or last ce, and
  // the LED parity. A ce is due once the elapsed count reaches the period.
  // --------------------------------------------------------------------------
  typedef enum {M_STEP, M_RUN, M_HALT} mmode_e;

  mmode_e m_mode    = M_STEP;
  int     m_elapsed = 0;
  bit     m_ce      = 1'b0;
  bit     m_led     = 1'b0;

  function automatic int period(input logic [1:0] s);
    int d;
    int p;
    d = 1;
    for (int i = 0; i < int'(s); i++) d = d * 4;
    p = DM / d;
    return (p < 1) ? 1 : p;
  endfunction

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m_mode    = M_STEP;
      m_elapsed = 0;
      m_ce      = 1'b0;
      m_led     = 1'b0;
    end else begin
      m_ce = 1'b0;
      if (m_mode != M_HALT) begin
        if (bus.hlt) begin
          m_mode = M_HALT;
        end else if (bus.mode_toggle) begin
          m_mode    = (m_mode == M_RUN) ? M_STEP : M_RUN;
          m_elapsed = 0;
        end else if (m_mode == M_STEP) begin
          m_ce = bus.step;
        end else begin
          m_elapsed++;
          if (m_elapsed >= period(bus.speed)) begin
            m_ce      = 1'b1;
            m_elapsed = 0;
          end
        end
      end
      if (m_ce) m_led = !m_led;
    end
  end

  always @(posedge clk) cyc++;

  // Every-cycle comparison, plus a log of ce cycles and LED values at ce.
  int ce_log[$];
  int led_log[$];

  always @(negedge clk) begin
    check("cpu_ce",   int'(bus.cpu_ce),   int'(m_ce));
    check("mode_run", int'(bus.mode_run), int'(m_mode == M_RUN));
    check("halted",   int'(bus.halted),   int'(m_mode == M_HALT));
    check("clk_led",  int'(bus.clk_led),  int'(m_led));
    if (bus.cpu_ce === 1'b1) begin
      ce_log.push_back(cyc);
      led_log.push_back(int'(bus.clk_led));
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_toggle();
    bus.mode_toggle = 1'b1;
    tick();
    bus.mode_toggle = 1'b0;
  endtask

  task automatic pulse_step();
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_ce"},     int'(bus.cpu_ce),   0);
    check({name, "_run"},    int'(bus.mode_run), 0);
    check({name, "_halted"}, int'(bus.halted),   0);
    check({name, "_led"},    int'(bus.clk_led),  0);
  endtask

  // Expected ce cycles: first + k*gap for k = 0..n-1.
  task automatic check_ce_train(input string name, input int first, input int gap, input int n);
    check({name, "_count"}, ce_log.size(), n);
    for (int k = 0; k < n && k < ce_log.size(); k++) begin
      check({name, "_at"}, ce_log[k], first + k * gap);
    end
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  int entry;
  int step_cyc[3];
  int run_gap[4] = '{16, 4, 1, 1};

  initial begin
    clr             = 1'b0;
    bus.mode_toggle = 1'b0;
    bus.step        = 1'b0;
    bus.speed       = 2'd0;
    bus.hlt         = 1'b0;

    // Reset held with inputs toggling: the compare process expects all-zero.
    for (int i = 0; i < 5; i++) begin
      bus.step        = i[0];
      bus.mode_toggle = ~i[0];
      bus.hlt         = i[1];
      bus.speed       = i[1:0];
      tick();
    end
    bus.step        = 1'b0;
    bus.mode_toggle = 1'b0;
    bus.hlt         = 1'b0;
    bus.speed       = 2'd0;
    clr             = 1'b1;
    tick();
    check_outputs_zero("after_reset");

    // STEP: three pulses 5 cycles apart, ce one cycle after each.
    ce_log.delete();
    led_log.delete();
    for (int k = 0; k < 3; k++) begin
      step_cyc[k] = cyc;
      pulse_step();
      tick(4);
    end
    check("step_ce_count", ce_log.size(), 3);
    if (ce_log.size() == 3) begin
      for (int k = 0; k < 3; k++) check("step_latency", ce_log[k] - step_cyc[k], 1);
      check("step_led0", led_log[0], 1);
      check("step_led1", led_log[1], 0);
      check("step_led2", led_log[2], 1);
    end

    // RUN at each speed for 39 cycles, then toggle out on cycle 40.
    for (int s = 0; s < 4; s++) begin
      bus.speed = 2'(s);
      pulse_toggle();
      check("run_entered", int'(bus.mode_run), 1);
      entry = cyc;
      ce_log.delete();
      tick(39);
      pulse_toggle();
      check("run_exited", int'(bus.mode_run), 0);
      check_ce_train($sformatf("run_speed%0d", s), entry + run_gap[s], run_gap[s], 39 / run_gap[s]);
    end

    // Speed change at cnt = 10: 0 -> 1 gives ce next cycle, then every 4.
    bus.speed = 2'd0;
    pulse_toggle();
    entry = cyc;
    ce_log.delete();
    tick(10);
    bus.speed = 2'd1;
    tick(20);
    pulse_toggle();
    check_ce_train("speed_change", entry + 11, 4, 5);

    // mode_toggle together with step in STEP: enters RUN, no ce.
    bus.speed       = 2'd1;
    bus.mode_toggle = 1'b1;
    bus.step        = 1'b1;
    tick();
    bus.mode_toggle = 1'b0;
    bus.step        = 1'b0;
    check("toggle_step_ce",  int'(bus.cpu_ce),   0);
    check("toggle_step_run", int'(bus.mode_run), 1);

    // mode_toggle on the terminal count in RUN (limit 4): back to STEP, no ce.
    ce_log.delete();
    tick(3);
    pulse_toggle();
    check("toggle_tc_ce",    int'(bus.cpu_ce),   0);
    check("toggle_tc_run",   int'(bus.mode_run), 0);
    check("toggle_tc_count", ce_log.size(),      0);

    // hlt on the terminal count in RUN: no ce, halted from that edge on.
    pulse_toggle();
    ce_log.delete();
    tick(3);
    bus.hlt = 1'b1;
    tick();
    check("halt_ce",     int'(bus.cpu_ce), 0);
    check("halt_halted", int'(bus.halted), 1);
    tick(2);
    bus.hlt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pulse_step();
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      pulse_toggle();
      tick();
    end
    check("halt_sticky",   int'(bus.halted),   1);
    check("halt_no_run",   int'(bus.mode_run), 0);
    check("halt_ce_count", ce_log.size(),      0);

    // clr mid-cycle while halted: outputs clear without a clock edge.
    #2;
    clr = 1'b0;
    #1;
    check_outputs_zero("clr_halted");
    tick(2);
    clr = 1'b1;
    tick();
    check_outputs_zero("after_clr_halted");

    // clr mid-pulse while RUN at limit 1 (ce continuously high).
    bus.speed = 2'd2;
    pulse_toggle();
    tick(4);
    check("run_ce_high", int'(bus.cpu_ce), 1);
    #2;
    clr = 1'b0;
    #1;
    check_outputs_zero("clr_run");
    tick(2);
    clr = 1'b1;
    tick(2);
    check("after_clr_run_mode", int'(bus.mode_run), 0);
    check("after_clr_run_ce",   int'(bus.cpu_ce),   0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
